// File: rtl/regfile_hazard_unit_if.sv
// Decode-stage register file / hazard unit bus.
// The pipeline control side drives through the master modport and
// regfile_hazard_unit consumes it through the slave modport.
interface regfile_hazard_unit_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
);
    logic [NRD*AW-1:0]   id_rs_addr;
    logic [NRD-1:0]      id_rs_valid;
    logic [NRD*XLEN-1:0] id_rs_data;
    logic [NRD*AW-1:0]   ex_rs_addr;
    logic [AW-1:0]       exm_rd_addr;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                wb_long;
    logic                issue_valid;
    logic                issue_long;
    logic [AW-1:0]       issue_rd;
    logic                flush;
    logic [NRD*2-1:0]    fwd_sel;
    logic                stall;
    logic                sb_err;

    modport master (
        output id_rs_addr, id_rs_valid, ex_rs_addr, exm_rd_addr,
               wb_en, wb_addr, wb_data, wb_long,
               issue_valid, issue_long, issue_rd, flush,
        input  id_rs_data, fwd_sel, stall, sb_err
    );

    modport slave (
        input  id_rs_addr, id_rs_valid, ex_rs_addr, exm_rd_addr,
               wb_en, wb_addr, wb_data, wb_long,
               issue_valid, issue_long, issue_rd, flush,
        output id_rs_data, fwd_sel, stall, sb_err
    );
endinterface

// File: rtl/regfile_hazard_unit.sv
// Decode-stage register file with same-cycle writeback bypass, per-port
// forwarding-select generation for the execute muxes, and a scoreboard of
// in-flight long-latency destinations that drives the load-use stall.
module regfile_hazard_unit #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int MAX_PEND = 3,
    parameter int AW       = $clog2(NREG),
    parameter int PW       = $clog2(MAX_PEND + 1)
) (
    input logic                 clk,
    input logic                 rst,
    regfile_hazard_unit_if.slave bus
);

    localparam logic [PW-1:0] PEND_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PEND_ONE  = PW'(1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PEND);
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

    // Architectural state. Entry 0 is never written, so it stays zero.
    logic [XLEN-1:0] regs_r     [NREG];
    logic [PW-1:0]   pend_r     [NREG];
    logic [PW-1:0]   pend_nxt_s [NREG];
    logic            sb_err_r;
    logic            err_set_s;

    logic            inc_s;
    logic            dec_s;
    logic            full_issue_s;
    logic            stall_s;
    logic [NRD-1:0]  blocked_vec_s;

    // Scoreboard increment/decrement qualifiers; register 0 never tracks.
    always_comb begin
        inc_s = bus.issue_valid & bus.issue_long & ~stall_s & (bus.issue_rd != ADDR_ZERO);
        dec_s = bus.wb_en & bus.wb_long & (bus.wb_addr != ADDR_ZERO);
    end

    // Stall when any read port is blocked or a new long op would overflow its counter.
    always_comb begin
        if (bus.issue_long && bus.issue_valid && (pend_r[bus.issue_rd] == PEND_MAX)) begin
            full_issue_s = 1'b1;
        end else begin
            full_issue_s = 1'b0;
        end
        stall_s = (|blocked_vec_s) | full_issue_s;
    end

    assign bus.stall  = stall_s;
    assign bus.sb_err = sb_err_r;

    for (genvar gi = 0; gi < NRD; gi++) begin : g_port
        logic [AW-1:0]   id_addr_s;
        logic [AW-1:0]   ex_addr_s;
        logic [PW-1:0]   id_pend_s;
        logic [XLEN-1:0] data_s;
        logic [1:0]      sel_s;
        logic            blocked_s;

        assign id_addr_s = bus.id_rs_addr[gi*AW +: AW];
        assign ex_addr_s = bus.ex_rs_addr[gi*AW +: AW];
        assign id_pend_s = pend_r[id_addr_s];

        // Operand read: x0 is zero, a same-cycle writeback wins over the array.
        always_comb begin
            if (id_addr_s == ADDR_ZERO) begin
                data_s = {XLEN{1'b0}};
            end else if (bus.wb_en && (bus.wb_addr == id_addr_s)) begin
                data_s = bus.wb_data;
            end else begin
                data_s = regs_r[id_addr_s];
            end
        end

        // Forwarding select for the execute mux; the younger EX/MEM result has priority.
        always_comb begin
            if (ex_addr_s == ADDR_ZERO) begin
                sel_s = 2'd0;
            end else if (ex_addr_s == bus.exm_rd_addr) begin
                sel_s = 2'd1;
            end else if (bus.wb_en && (ex_addr_s == bus.wb_addr)) begin
                sel_s = 2'd2;
            end else begin
                sel_s = 2'd0;
            end
        end

        // Load-use block, except when the last owed write lands this cycle and is bypassed.
        always_comb begin
            if (bus.id_rs_valid[gi] && (id_addr_s != ADDR_ZERO) && (id_pend_s != PEND_ZERO)) begin
                if ((id_pend_s == PEND_ONE) && dec_s && (bus.wb_addr == id_addr_s)) begin
                    blocked_s = 1'b0;
                end else begin
                    blocked_s = 1'b1;
                end
            end else begin
                blocked_s = 1'b0;
            end
        end

        assign bus.id_rs_data[gi*XLEN +: XLEN] = data_s;
        assign bus.fwd_sel[gi*2 +: 2]          = sel_s;
        assign blocked_vec_s[gi]               = blocked_s;
    end

    // Next scoreboard counts; inc+dec on one register cancel, flush clears everything.
    always_comb begin
        err_set_s = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            pend_nxt_s[r] = pend_r[r];
        end
        for (int r = 0; r < NREG; r++) begin
            if (inc_s && (bus.issue_rd == AW'(r)) && !(dec_s && (bus.wb_addr == AW'(r)))) begin
                if (pend_r[r] == PEND_MAX) begin
                    err_set_s = 1'b1;
                end else begin
                    pend_nxt_s[r] = pend_r[r] + PEND_ONE;
                end
            end else if (dec_s && (bus.wb_addr == AW'(r)) && !(inc_s && (bus.issue_rd == AW'(r)))) begin
                if (pend_r[r] == PEND_ZERO) begin
                    err_set_s = 1'b1;
                end else begin
                    pend_nxt_s[r] = pend_r[r] - PEND_ONE;
                end
            end else begin
                pend_nxt_s[r] = pend_r[r];
            end
        end
        if (bus.flush) begin
            for (int r = 0; r < NREG; r++) begin
                pend_nxt_s[r] = PEND_ZERO;
            end
        end else begin
            err_set_s = err_set_s;
        end
    end

    // Register array write; writes to x0 are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_r[r] <= {XLEN{1'b0}};
            end
        end else if (bus.wb_en && (bus.wb_addr != ADDR_ZERO)) begin
            regs_r[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Scoreboard counters and the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                pend_r[r] <= PEND_ZERO;
            end
            sb_err_r <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pend_r[r] <= pend_nxt_s[r];
            end
            sb_err_r <= sb_err_r | err_set_s;
        end
    end

endmodule

// File: tb/tb_regfile_hazard_unit.sv
// Directed testbench for regfile_hazard_unit: bypass, forwarding selects,
// load-use stall, scoreboard saturation, flush and the sticky error flag.
module tb_regfile_hazard_unit;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int MAXP = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    regfile_hazard_unit_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus_if ();

    regfile_hazard_unit #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .MAX_PEND(MAXP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus_if.id_rs_addr  = 10'd0;
        bus_if.id_rs_valid = 2'b00;
        bus_if.ex_rs_addr  = 10'd0;
        bus_if.exm_rd_addr = 5'd0;
        bus_if.wb_en       = 1'b0;
        bus_if.wb_addr     = 5'd0;
        bus_if.wb_data     = 32'd0;
        bus_if.wb_long     = 1'b0;
        bus_if.issue_valid = 1'b0;
        bus_if.issue_long  = 1'b0;
        bus_if.issue_rd    = 5'd0;
        bus_if.flush       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus_if.wb_en = 1'b1; bus_if.wb_addr = 5'd4; bus_if.wb_data = 32'hAAAA_5555;
        bus_if.issue_valid = 1'b1; bus_if.issue_long = 1'b1; bus_if.issue_rd = 5'd6;
        tick();
        idle();
        bus_if.wb_en = 1'b1; bus_if.wb_long = 1'b1; bus_if.wb_addr = 5'd8;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus_if.sb_err !== 1'b1) begin n_fail++; $display("FAIL pre_reset_err: sb_err=%b expected 1", bus_if.sb_err); end
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            bus_if.id_rs_addr = {r[4:0], r[4:0]};
            #1;
            n_checks++;
            if (bus_if.id_rs_data !== 64'd0) begin
                n_fail++; $display("FAIL reset_read x%0d: data=%h expected 0", r, bus_if.id_rs_data);
            end
        end
        bus_if.id_rs_valid = 2'b11; bus_if.id_rs_addr = {5'd6, 5'd4};
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: stall=%b expected 0", bus_if.stall); end
        n_checks++;
        if (bus_if.sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: sb_err=%b expected 0", bus_if.sb_err); end
        n_checks++;
        if (bus_if.fwd_sel !== 4'd0) begin n_fail++; $display("FAIL reset_fwd: fwd_sel=%b expected 0000", bus_if.fwd_sel); end
        idle();
        tick();
    endtask

    task automatic test_bypass();
        idle();
        bus_if.wb_en = 1'b1; bus_if.wb_addr = 5'd5; bus_if.wb_data = 32'hDEAD_BEEF;
        bus_if.id_rs_addr = {5'd0, 5'd5};
        #1;
        n_checks++;
        if (bus_if.id_rs_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_p0: data=%h expected deadbeef", bus_if.id_rs_data[31:0]); end
        n_checks++;
        if (bus_if.id_rs_data[63:32] !== 32'd0) begin n_fail++; $display("FAIL bypass_x0_p1: data=%h expected 0", bus_if.id_rs_data[63:32]); end
        tick();
        bus_if.wb_en = 1'b0;
        #1;
        n_checks++;
        if (bus_if.id_rs_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL array_p0: data=%h expected deadbeef", bus_if.id_rs_data[31:0]); end
        bus_if.wb_en = 1'b1; bus_if.wb_addr = 5'd0; bus_if.wb_data = 32'h0000_1234;
        bus_if.id_rs_addr = {5'd5, 5'd0};
        #1;
        n_checks++;
        if (bus_if.id_rs_data[31:0] !== 32'd0) begin n_fail++; $display("FAIL x0_bypass: data=%h expected 0", bus_if.id_rs_data[31:0]); end
        n_checks++;
        if (bus_if.id_rs_data[63:32] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL array_p1: data=%h expected deadbeef", bus_if.id_rs_data[63:32]); end
        tick();
        bus_if.wb_en = 1'b0;
        #1;
        n_checks++;
        if (bus_if.id_rs_data[31:0] !== 32'd0) begin n_fail++; $display("FAIL x0_array: data=%h expected 0", bus_if.id_rs_data[31:0]); end
        bus_if.wb_en = 1'b1; bus_if.wb_addr = 5'd5; bus_if.wb_data = 32'h0BAD_F00D;
        #1;
        n_checks++;
        if (bus_if.id_rs_data[63:32] !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL bypass_p1: data=%h expected 0badf00d", bus_if.id_rs_data[63:32]); end
        tick();
        idle();
    endtask

    task automatic test_fwd();
        idle();
        bus_if.ex_rs_addr = {5'd7, 5'd0}; bus_if.exm_rd_addr = 5'd7;
        bus_if.wb_en = 1'b1; bus_if.wb_addr = 5'd7; bus_if.wb_data = 32'h7777_7777;
        #1;
        n_checks++;
        if (bus_if.fwd_sel !== 4'b0100) begin n_fail++; $display("FAIL fwd_exmem: fwd_sel=%b expected 0100", bus_if.fwd_sel); end
        bus_if.exm_rd_addr = 5'd0;
        #1;
        n_checks++;
        if (bus_if.fwd_sel !== 4'b1000) begin n_fail++; $display("FAIL fwd_memwb: fwd_sel=%b expected 1000", bus_if.fwd_sel); end
        bus_if.ex_rs_addr = 10'd0;
        #1;
        n_checks++;
        if (bus_if.fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL fwd_none: fwd_sel=%b expected 0000", bus_if.fwd_sel); end
        bus_if.ex_rs_addr = {5'd0, 5'd7}; bus_if.exm_rd_addr = 5'd7;
        #1;
        n_checks++;
        if (bus_if.fwd_sel !== 4'b0001) begin n_fail++; $display("FAIL fwd_p0: fwd_sel=%b expected 0001", bus_if.fwd_sel); end
        bus_if.exm_rd_addr = 5'd3; bus_if.wb_en = 1'b0;
        #1;
        n_checks++;
        if (bus_if.fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL fwd_wb_off: fwd_sel=%b expected 0000", bus_if.fwd_sel); end
        tick();
        idle();
    endtask

    task automatic test_load_use();
        idle();
        bus_if.issue_valid = 1'b1; bus_if.issue_long = 1'b1; bus_if.issue_rd = 5'd3;
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b0) begin n_fail++; $display("FAIL lu_issue: stall=%b expected 0", bus_if.stall); end
        tick();
        idle();
        bus_if.id_rs_valid = 2'b01; bus_if.id_rs_addr = {5'd0, 5'd3};
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall1: stall=%b expected 1", bus_if.stall); end
        tick();
        bus_if.issue_valid = 1'b1; bus_if.issue_long = 1'b1; bus_if.issue_rd = 5'd3;
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall2: stall=%b expected 1", bus_if.stall); end
        tick();
        bus_if.issue_valid = 1'b0; bus_if.issue_long = 1'b0;
        bus_if.wb_en = 1'b1; bus_if.wb_long = 1'b1; bus_if.wb_addr = 5'd3; bus_if.wb_data = 32'h0000_0055;
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: stall=%b expected 0", bus_if.stall); end
        n_checks++;
        if (bus_if.id_rs_data[31:0] !== 32'h0000_0055) begin n_fail++; $display("FAIL lu_bypass: data=%h expected 55", bus_if.id_rs_data[31:0]); end
        tick();
        bus_if.wb_en = 1'b0; bus_if.wb_long = 1'b0;
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b0) begin n_fail++; $display("FAIL lu_after: stall=%b expected 0", bus_if.stall); end
        n_checks++;
        if (bus_if.id_rs_data[31:0] !== 32'h0000_0055) begin n_fail++; $display("FAIL lu_array: data=%h expected 55", bus_if.id_rs_data[31:0]); end
        idle();
    endtask

    task automatic test_max_pend();
        idle();
        bus_if.issue_valid = 1'b1; bus_if.issue_long = 1'b1; bus_if.issue_rd = 5'd9;
        for (int k = 0; k < MAXP; k++) begin
            #1;
            n_checks++;
            if (bus_if.stall !== 1'b0) begin n_fail++; $display("FAIL mp_issue%0d: stall=%b expected 0", k, bus_if.stall); end
            tick();
        end
        n_checks++;
        if (bus_if.stall !== 1'b1) begin n_fail++; $display("FAIL mp_full: stall=%b expected 1", bus_if.stall); end
        tick();
        n_checks++;
        if (bus_if.stall !== 1'b1) begin n_fail++; $display("FAIL mp_held: stall=%b expected 1", bus_if.stall); end
        idle();
        bus_if.wb_en = 1'b1; bus_if.wb_long = 1'b1; bus_if.wb_addr = 5'd9;
        bus_if.id_rs_valid = 2'b01; bus_if.id_rs_addr = {5'd0, 5'd9};
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b1) begin n_fail++; $display("FAIL mp_read_dec: stall=%b expected 1", bus_if.stall); end
        tick();
        idle();
        bus_if.issue_valid = 1'b1; bus_if.issue_long = 1'b1; bus_if.issue_rd = 5'd9;
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b0) begin n_fail++; $display("FAIL mp_accept: stall=%b expected 0", bus_if.stall); end
        tick();
        n_checks++;
        if (bus_if.stall !== 1'b1) begin n_fail++; $display("FAIL mp_refull: stall=%b expected 1", bus_if.stall); end
        idle();
        bus_if.wb_en = 1'b1; bus_if.wb_long = 1'b1; bus_if.wb_addr = 5'd9;
        tick();
        bus_if.issue_valid = 1'b1; bus_if.issue_long = 1'b1; bus_if.issue_rd = 5'd9;
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b0) begin n_fail++; $display("FAIL mp_simul: stall=%b expected 0", bus_if.stall); end
        tick();
        idle();
        bus_if.issue_valid = 1'b1; bus_if.issue_long = 1'b1; bus_if.issue_rd = 5'd9;
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b0) begin n_fail++; $display("FAIL mp_simul_kept2: stall=%b expected 0", bus_if.stall); end
        tick();
        n_checks++;
        if (bus_if.stall !== 1'b1) begin n_fail++; $display("FAIL mp_simul_to3: stall=%b expected 1", bus_if.stall); end
        idle();
    endtask

    task automatic test_flush();
        idle();
        bus_if.issue_valid = 1'b1; bus_if.issue_long = 1'b1; bus_if.issue_rd = 5'd3;
        tick();
        bus_if.issue_rd = 5'd12;
        tick();
        idle();
        bus_if.id_rs_valid = 2'b11; bus_if.id_rs_addr = {5'd12, 5'd3};
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b1) begin n_fail++; $display("FAIL fl_pre: stall=%b expected 1", bus_if.stall); end
        idle();
        bus_if.flush = 1'b1;
        bus_if.wb_en = 1'b1; bus_if.wb_addr = 5'd20; bus_if.wb_data = 32'hCAFE_F00D;
        tick();
        idle();
        bus_if.id_rs_valid = 2'b11; bus_if.id_rs_addr = {5'd12, 5'd3};
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b0) begin n_fail++; $display("FAIL fl_read: stall=%b expected 0", bus_if.stall); end
        bus_if.id_rs_valid = 2'b00;
        bus_if.issue_valid = 1'b1; bus_if.issue_long = 1'b1; bus_if.issue_rd = 5'd9;
        #1;
        n_checks++;
        if (bus_if.stall !== 1'b0) begin n_fail++; $display("FAIL fl_x9: stall=%b expected 0", bus_if.stall); end
        idle();
        bus_if.id_rs_addr = {5'd20, 5'd0};
        #1;
        n_checks++;
        if (bus_if.id_rs_data[63:32] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL fl_write: data=%h expected cafef00d", bus_if.id_rs_data[63:32]); end
        n_checks++;
        if (bus_if.sb_err !== 1'b0) begin n_fail++; $display("FAIL fl_err0: sb_err=%b expected 0", bus_if.sb_err); end
        idle();
        bus_if.wb_en = 1'b1; bus_if.wb_long = 1'b1; bus_if.wb_addr = 5'd3; bus_if.wb_data = 32'h0000_0001;
        tick();
        idle();
        n_checks++;
        if (bus_if.sb_err !== 1'b1) begin n_fail++; $display("FAIL err_set: sb_err=%b expected 1", bus_if.sb_err); end
        repeat (3) tick();
        n_checks++;
        if (bus_if.sb_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: sb_err=%b expected 1", bus_if.sb_err); end
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus_if.sb_err !== 1'b0) begin n_fail++; $display("FAIL err_reset: sb_err=%b expected 0", bus_if.sb_err); end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        test_reset();
        test_bypass();
        test_fwd();
        test_load_use();
        test_max_pend();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
